// File: rtl/ureg_pkg.sv
// Shared encodings for the universal-register command sequencer:
// the register op codes and the sequencer FSM states.
package ureg_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP   = 2'd0;
    localparam op_t OP_RIGHT = 2'd1;
    localparam op_t OP_LEFT  = 2'd2;
    localparam op_t OP_LOAD  = 2'd3;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_CAPT = 2'd2;

    function automatic logic op_is_shift(input op_t op);
        return (op == OP_RIGHT) || (op == OP_LEFT);
    endfunction

    // A NOP or a zero-length shift has nothing to drive, so it goes straight to capture.
    function automatic logic needs_exec(input op_t op, input logic count_zero);
        return (op == OP_LOAD) || (op_is_shift(op) && !count_zero);
    endfunction

endpackage

// File: rtl/ureg_seq_ctrl_if.sv
// Command, register-control and status signals between the sequencer
// (slave view) and whoever issues commands and owns the register (master view).
interface ureg_seq_ctrl_if
    import ureg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;

    op_t              reg_select;
    logic [WIDTH-1:0] reg_p_din;
    logic             reg_s_left_din;
    logic             reg_s_right_din;
    logic [WIDTH-1:0] reg_p_dout;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data, reg_p_dout,
        output cmd_ready, reg_select, reg_p_din, reg_s_left_din, reg_s_right_din,
               busy, done, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data, reg_p_dout,
        input  cmd_ready, reg_select, reg_p_din, reg_s_left_din, reg_s_right_din,
               busy, done, result
    );

endinterface

// File: rtl/ureg_cmd_fifo2.sv
// Two-entry command FIFO; a push while full is dropped even if a pop
// happens in the same cycle, so full only ever reflects registered state.
module ureg_cmd_fifo2 #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ureg_seq_ctrl.sv
// Sequences queued shift/load commands onto an external universal register
// and captures the register contents when each command completes.
module ureg_seq_ctrl
    import ureg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ureg_seq_ctrl_if.slave bus
);

    localparam int DW = 2 + CNT_W + 1 + WIDTH;

    logic [DW-1:0]    head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             take_head;
    op_t              head_op;
    logic [CNT_W-1:0] head_count;
    logic             head_fill;
    logic [WIDTH-1:0] head_data;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              cur_op_q, cur_op_d;
    logic             cur_fill_q, cur_fill_d;
    logic [WIDTH-1:0] cur_data_q, cur_data_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             in_exec;
    logic             in_shift;

    ureg_cmd_fifo2 #(.DW(DW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (bus.cmd_valid),
        .push_data_i({bus.cmd_op, bus.cmd_count, bus.cmd_fill, bus.cmd_data}),
        .pop_i      (take_head),
        .pop_data_o (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign {head_op, head_count, head_fill, head_data} = head;

    // The head is taken both from IDLE and straight out of CAPT, which is what
    // lets queued commands run back to back without an idle cycle in between.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_op_d   = cur_op_q;
        cur_fill_d = cur_fill_q;
        cur_data_d = cur_data_q;
        result_d   = result_q;
        done_d     = 1'b0;
        take_head  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_head = !fifo_empty;
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                result_d  = bus.reg_p_dout;
                done_d    = 1'b1;
                take_head = !fifo_empty;
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_head) begin
            cur_op_d   = head_op;
            cur_fill_d = head_fill;
            cur_data_d = head_data;
            cnt_d      = '0;
            if (needs_exec(head_op, head_count == '0)) begin
                state_d = ST_EXEC;
                if (op_is_shift(head_op)) begin
                    cnt_d = head_count - CNT_W'(1);
                end
            end else begin
                state_d = ST_CAPT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_op_q   <= OP_NOP;
            cur_fill_q <= 1'b0;
            cur_data_q <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_op_q   <= cur_op_d;
            cur_fill_q <= cur_fill_d;
            cur_data_q <= cur_data_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign in_exec  = (state_q == ST_EXEC);
    assign in_shift = in_exec && op_is_shift(cur_op_q);

    assign bus.cmd_ready       = !fifo_full;
    assign bus.reg_select      = in_exec ? cur_op_q : OP_NOP;
    assign bus.reg_p_din       = (in_exec && cur_op_q == OP_LOAD) ? cur_data_q : '0;
    assign bus.reg_s_left_din  = in_shift & cur_fill_q;
    assign bus.reg_s_right_din = in_shift & cur_fill_q;
    assign bus.busy            = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.done            = done_q;
    assign bus.result          = result_q;

endmodule

// File: tb/tb_ureg_seq_ctrl.sv
// Bench for ureg_seq_ctrl: a behavioural universal register is attached and
// every completion is compared with a reference model of the command rules.
module tb_ureg_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [WIDTH-1:0] ureg    = '0;
    logic [WIDTH-1:0] mdl_reg = '0;

    ureg_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    ureg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // The controlled universal register: 1 shifts toward the LSB, 2 toward the MSB.
    always @(posedge clk) begin
        case (bus.reg_select)
            2'd1:    ureg <= {bus.reg_s_right_din, ureg[WIDTH-1:1]};
            2'd2:    ureg <= {ureg[WIDTH-2:0], bus.reg_s_left_din};
            2'd3:    ureg <= bus.reg_p_din;
            default: ;
        endcase
    end

    assign bus.reg_p_dout = ureg;

    function automatic logic [WIDTH-1:0] ref_next(input int op, input int n, input logic fill,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] cur);
        int full = 1 << WIDTH;
        int v;
        if (op == 3) return data;
        if (op == 0 || n == 0) return cur;
        if (n >= WIDTH) return fill ? WIDTH'(full - 1) : '0;
        if (op == 1) v = int'(cur) / (1 << n) + (fill ? full - (full >> n) : 0);
        else         v = (int'(cur) * (1 << n)) % full + (fill ? (1 << n) - 1 : 0);
        return WIDTH'(v);
    endfunction

    function automatic int ref_sel(input int op, input int n);
        if (op == 3) return 1;
        if (op == 0) return 0;
        return n;
    endfunction

    function automatic int ref_lat(input int op, input int n);
        return ref_sel(op, n) + 2;
    endfunction

    // Issues one command into an idle, empty sequencer and observes it until done.
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic fill,
                           input logic [WIDTH-1:0] data,
                           output int lat, output int sel_cycles, output int bad_drive);
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_fill  = fill;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat        = -1;
        sel_cycles = 0;
        bad_drive  = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.reg_select !== 2'd0) begin
                sel_cycles++;
                if (bus.reg_select !== op) bad_drive++;
                if (op == 2'd3 && bus.reg_p_din !== data) bad_drive++;
                if (op != 2'd3 && (bus.reg_s_left_din !== fill || bus.reg_s_right_din !== fill))
                    bad_drive++;
            end else if (bus.reg_p_din !== '0 || bus.reg_s_left_din !== 1'b0 ||
                         bus.reg_s_right_din !== 1'b0) begin
                bad_drive++;
            end
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd3;
        bus.cmd_count = '0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_data  = 4'h9;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.reg_select !== 2'd0 || bus.reg_p_din !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_drive: select=%0d p_din=%h, required 0/0", bus.reg_select, bus.reg_p_din);
        end
        tests_run++;
        if (bus.reg_s_left_din !== 1'b0 || bus.reg_s_right_din !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_serial: left=%b right=%b, required 0/0", bus.reg_s_left_din, bus.reg_s_right_din);
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: done=%b busy=%b result=%h, required 0/0/0", bus.done, bus.busy, bus.result);
        end
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b, required 1", bus.cmd_ready);
        end
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_push_ignored: busy=%b done=%b, required 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_single(input string name, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                               input logic fill, input logic [WIDTH-1:0] data);
        int lat, sel, bad;
        logic [WIDTH-1:0] exp_res;
        exp_res = ref_next(op, cnt, fill, data, mdl_reg);
        run_cmd(op, cnt, fill, data, lat, sel, bad);
        tests_run++;
        if (lat != ref_lat(op, cnt)) begin
            tests_failed++;
            $display("[TB] FAIL %s_latency: got %0d, required %0d", name, lat, ref_lat(op, cnt));
        end
        tests_run++;
        if (sel != ref_sel(op, cnt) || bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_select: %0d cycles (%0d bad), required %0d cycles", name, sel, bad, ref_sel(op, cnt));
        end
        tests_run++;
        if (bus.result !== exp_res) begin
            tests_failed++;
            $display("[TB] FAIL %s_result: got %h, required %h", name, bus.result, exp_res);
        end
        mdl_reg = exp_res;
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_res) begin
            tests_failed++;
            $display("[TB] FAIL %s_after: done=%b busy=%b result=%h, required 0/0/%h", name, bus.done, bus.busy, bus.result, exp_res);
        end
    endtask

    task automatic test_load();
        test_single("load", 2'd3, 3'd0, 1'b0, 4'hA);
    endtask

    task automatic test_shift_right();
        test_single("shift_right2", 2'd1, 3'd2, 1'b1, 4'h0);
    endtask

    task automatic test_shift_zero();
        test_single("shift_left0", 2'd2, 3'd0, 1'b1, 4'h5);
    endtask

    task automatic test_shift_left7();
        test_single("load_f", 2'd3, 3'd0, 1'b1, 4'hF);
        test_single("shift_left7", 2'd2, 3'd7, 1'b0, 4'h3);
    endtask

    task automatic test_back_to_back();
        logic [1:0]       ops   [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
        logic [CNT_W-1:0] cnts  [4] = '{3'd3, 3'd0, 3'd1, 3'd5};
        logic             fills [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] datas [4] = '{4'h7, 4'h5, 4'h0, 4'hC};
        logic [WIDTH-1:0] exp_res [4];
        int next_push = 0, dones = 0, last_done = -1, stalls = 0, idle_seen = 0;
        logic ready_prev, valid_prev;
        for (int k = 0; k < 4; k++) begin
            exp_res[k] = ref_next(ops[k], cnts[k], fills[k], datas[k], k == 0 ? mdl_reg : exp_res[k-1]);
        end
        bus.cmd_op = ops[0]; bus.cmd_count = cnts[0]; bus.cmd_fill = fills[0]; bus.cmd_data = datas[0];
        bus.cmd_valid = 1'b1;
        ready_prev = bus.cmd_ready;
        valid_prev = 1'b1;
        for (int cyc = 0; cyc < 80 && dones < 4; cyc++) begin
            @(negedge clk);
            if (valid_prev && ready_prev) next_push++;
            if (next_push < 4) begin
                bus.cmd_op = ops[next_push]; bus.cmd_count = cnts[next_push];
                bus.cmd_fill = fills[next_push]; bus.cmd_data = datas[next_push];
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.cmd_valid && !bus.cmd_ready) stalls++;
            ready_prev = bus.cmd_ready;
            valid_prev = bus.cmd_valid;
            if (bus.busy !== 1'b1 && dones < 3) idle_seen++;
            if (bus.done === 1'b1) begin
                tests_run++;
                if (bus.result !== exp_res[dones]) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_result%0d: got %h, required %h", dones, bus.result, exp_res[dones]);
                end
                if (dones > 0) begin
                    tests_run++;
                    if (cyc - last_done != ref_sel(ops[dones], cnts[dones]) + 1) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_gap%0d: got %0d cycles, required %0d", dones, cyc - last_done, ref_sel(ops[dones], cnts[dones]) + 1);
                    end
                end
                last_done = cyc;
                dones++;
            end
        end
        bus.cmd_valid = 1'b0;
        tests_run++;
        if (dones != 4) begin
            tests_failed++;
            $display("[TB] FAIL b2b_completions: got %0d, required 4", dones);
        end
        tests_run++;
        if (stalls == 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_backpressure: stalled cycles %0d, required at least 1", stalls);
        end
        tests_run++;
        if (idle_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_no_idle: busy low %0d cycles, required 0", idle_seen);
        end
        mdl_reg = exp_res[3];
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones = 0, busy_seen = 0;
        bus.cmd_op = 2'd1; bus.cmd_count = 3'd4; bus.cmd_fill = 1'b1; bus.cmd_data = '0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_op = 2'd3; bus.cmd_count = '0; bus.cmd_fill = 1'b0; bus.cmd_data = 4'h6;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.reg_select !== 2'd1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_second_cycle: select=%0d busy=%b, required 1/1", bus.reg_select, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.reg_select !== 2'd0 || bus.reg_p_din !== '0 || bus.reg_s_left_din !== 1'b0 ||
            bus.reg_s_right_din !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_drive: select=%0d p_din=%h sl=%b sr=%b, required all 0", bus.reg_select, bus.reg_p_din, bus.reg_s_left_din, bus.reg_s_right_din);
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.result !== '0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_status: done=%b result=%h busy=%b, required 0/0/0", bus.done, bus.result, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) dones++;
            if (bus.busy !== 1'b0) busy_seen++;
        end
        tests_run++;
        if (dones != 0 || busy_seen != 0 || bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_discard: dones=%0d busy_cycles=%0d ready=%b, required 0/0/1", dones, busy_seen, bus.cmd_ready);
        end
        mdl_reg = ref_next(1, 1, 1'b1, '0, mdl_reg);
    endtask

    task automatic test_random();
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
        logic             fill;
        logic [WIDTH-1:0] data;
        for (int k = 0; k < 24; k++) begin
            op   = (k == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            cnt  = CNT_W'($urandom_range(0, 7));
            fill = 1'($urandom_range(0, 1));
            data = WIDTH'($urandom_range(0, 15));
            test_single("random", op, cnt, fill, data);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_shift_zero();
        test_shift_left7();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/ureg_seq_ctrl.md
UREG_SEQ_CTRL -- requirements
Module: ureg_seq_ctrl

Interface
REQ-001 SHALL expose parameter WIDTH, default 4, width of the controlled universal register.
REQ-002 SHALL expose parameter CNT_W, default 3, width of the shift-count field.
REQ-003 SHALL have port clk, input, 1, single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command slot free.
REQ-007 SHALL have port cmd_op, input, 2, 0=NOP, 1=shift right, 2=shift left, 3=parallel load.
REQ-008 SHALL have port cmd_count, input, CNT_W, number of shift positions.
REQ-009 SHALL have port cmd_fill, input, 1, serial bit shifted in.
REQ-010 SHALL have port cmd_data, input, WIDTH, parallel load word.
REQ-011 SHALL have port reg_select, output, 2, register mode: 0 hold, 1 right, 2 left, 3 load.
REQ-012 SHALL have port reg_p_din, output, WIDTH, parallel word to register.
REQ-013 SHALL have port reg_s_left_din, output, 1, left-shift serial input.
REQ-014 SHALL have port reg_s_right_din, output, 1, right-shift serial input.
REQ-015 SHALL have port reg_p_dout, input, WIDTH, register contents.
REQ-016 SHALL have port busy, output, 1, command executing or queued.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port result, output, WIDTH, register contents captured at completion.

Function
REQ-019 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1, into a 2-entry FIFO.
REQ-020 SHALL drive cmd_ready = not FIFO-full, from registered state only; a push while full is dropped; push and pop in the same cycle are legal when not full.
REQ-021 SHALL implement FSM IDLE -> EXEC -> CAPT -> IDLE; it pops the FIFO head on leaving IDLE.
REQ-022 In EXEC, a load SHALL drive reg_select=3 and reg_p_din=cmd_data for exactly 1 cycle.
REQ-023 In EXEC, a shift of count N>=1 SHALL drive reg_select=op for exactly N consecutive cycles, with cmd_fill on both serial inputs; the down-counter runs N-1..0.
REQ-024 NOP, or a shift with count 0, SHALL skip EXEC (IDLE -> CAPT), with no non-zero reg_select.
REQ-025 Outside EXEC, reg_select SHALL be 0, and reg_p_din and both serial inputs SHALL be 0.
REQ-026 In CAPT, the block SHALL register reg_p_dout into result and pulse done for 1 cycle.
REQ-027 Latency from accept (FIFO empty, IDLE) to done SHALL be 1 + execute cycles + 1: load=3, shift N=N+2, NOP=2.
REQ-028 From CAPT, the FSM SHALL go to EXEC or CAPT directly if the FIFO is non-empty, giving back-to-back commands with no idle cycle.
REQ-029 busy SHALL be 1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-030 result SHALL hold its value between completions.
REQ-031 Counts up to 2^CNT_W-1 SHALL be executed literally; counts above WIDTH are not clamped.

Reset
REQ-032 While rst_n=0, the block SHALL set: FSM IDLE, FIFO empty, counter 0, reg_select 0, reg_p_din 0, serial inputs 0, done 0, result 0, busy 0.
REQ-033 Reset mid-command SHALL abort the command and discard queued commands, with no done pulse.
REQ-034 Pushes SHALL be ignored while rst_n=0, even though cmd_ready reads 1.

Structure
REQ-035 The op encodings (NOP/RIGHT/LEFT/LOAD) and FSM state encodings SHALL live in the shared package ureg_pkg.
REQ-036 The 2-entry command FIFO SHALL be a sub-module ureg_cmd_fifo2, carrying {op, count, fill, data}; the FSM and counter stay in the top.

Verification
REQ-037 Load 4'hA from reset, with the register model attached: the bench SHALL see reg_select=3 for 1 cycle, done at cycle 3, and result=4'hA.
REQ-038 Load 4'hA, then shift right with count 2 and fill=1: the bench SHALL see 2 cycles of reg_select=1, and result=4'hE.
REQ-039 Shift left with count 0: the bench SHALL see no reg_select activity, done 2 cycles after accept, and result unchanged.
REQ-040 Push 3 commands back-to-back while executing a shift of 3: cmd_ready SHALL drop after 2 queued, the third SHALL wait, and all SHALL complete in order with no idle gap.
REQ-041 Assert rst_n=0 during the second cycle of a shift-4 command with 1 queued: all outputs SHALL be 0 immediately, with no done, busy 0 after release, and FIFO empty.
REQ-042 Shift left with count 7 and fill=0 after loading 4'hF: the bench SHALL see 7 select cycles, and result=4'h0.
